// File: rtl/carfield_pwr_seq_pkg.sv
// Shared types and defaults for the carfield island power sequencer.
// pwr_state_e : states of the single shared sequencing FSM
// Default*    : default wait lengths in clock cycles
// max_u       : helper used to size the shared wait counter
package carfield_pwr_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClkOn,
    StRstOff,
    StIsoOff,
    StIsoOn,
    StClkOff,
    StRstOn,
    StDone
  } pwr_state_e;

  localparam int unsigned DefaultNumIslands      = 4;
  localparam int unsigned DefaultClkSettleCycles = 8;
  localparam int unsigned DefaultRstHoldCycles   = 16;
  localparam int unsigned DefaultIsoTimeout      = 1024;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/carfield_island_pwr_sequencer_rr.sv
// Round-robin picker for the island power sequencer.
// Rotates the pending vector so that rr_ptr_i lands on bit 0, finds the lowest set bit
// (trailing-zero count) and rotates the position back into an island index.
// pending_i : islands that need servicing
// rr_ptr_i  : first index to consider this round
// valid_o   : at least one island pending
// idx_o     : granted island index
module carfield_island_pwr_sequencer_rr #(
  parameter int unsigned NumIslands = 4,
  parameter int unsigned IdxW       = (NumIslands > 1) ? $clog2(NumIslands) : 1
) (
  input  logic [NumIslands-1:0] pending_i,
  input  logic [IdxW-1:0]       rr_ptr_i,
  output logic                  valid_o,
  output logic [IdxW-1:0]       idx_o
);

  logic [NumIslands-1:0] rot;
  logic [IdxW-1:0]       pos;
  int unsigned           sum;

  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < NumIslands; i++) begin
      rot[i] = pending_i[(i + int'(rr_ptr_i)) % NumIslands];
    end
    // Scan downwards so the lowest set bit wins.
    pos = '0;
    for (int i = int'(NumIslands) - 1; i >= 0; i--) begin
      if (rot[i]) pos = i[IdxW-1:0];
    end
    sum = int'(pos) + int'(rr_ptr_i);
    if (sum >= NumIslands) sum = sum - NumIslands;
    idx_o   = sum[IdxW-1:0];
    valid_o = |pending_i;
  end

endmodule

// File: rtl/carfield_island_pwr_sequencer.sv
// Clock / reset / AXI-isolation sequencer for the optional carfield islands.
// One shared FSM serves one island at a time; pending islands are granted round-robin.
// Up:   clk on -> settle -> reset release -> hold -> de-isolate -> wait ack -> on.
// Down: isolate -> wait ack (timeout forces on) -> clk off -> settle -> reset -> off.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   en_req_i       requested island state (level, 1 = on)
//   isolated_i     isolation ack per island
//   err_clr_i      pulse clearing the sticky error of an island
//   isolate_o      AXI isolation request
//   clk_en_o       island clock gate enable
//   island_rst_o   island reset, active-high
//   island_on_o    island fully powered and de-isolated
//   err_o          sticky isolation-ack timeout flag
//   busy_o         sequencer is serving an island
module carfield_island_pwr_sequencer
  import carfield_pwr_seq_pkg::*;
#(
  parameter int unsigned NumIslands      = DefaultNumIslands,
  parameter int unsigned ClkSettleCycles = DefaultClkSettleCycles,
  parameter int unsigned RstHoldCycles   = DefaultRstHoldCycles,
  parameter int unsigned IsoTimeout      = DefaultIsoTimeout
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumIslands-1:0] en_req_i,
  input  logic [NumIslands-1:0] isolated_i,
  input  logic [NumIslands-1:0] err_clr_i,
  output logic [NumIslands-1:0] isolate_o,
  output logic [NumIslands-1:0] clk_en_o,
  output logic [NumIslands-1:0] island_rst_o,
  output logic [NumIslands-1:0] island_on_o,
  output logic [NumIslands-1:0] err_o,
  output logic                  busy_o
);

  localparam int unsigned IdxW    = (NumIslands > 1) ? $clog2(NumIslands) : 1;
  localparam int unsigned MaxWait = max_u(max_u(ClkSettleCycles, RstHoldCycles), IsoTimeout);
  localparam int unsigned CntW    = $clog2(MaxWait + 1);

  localparam logic [CntW-1:0] ClkLast = CntW'(ClkSettleCycles - 1);
  localparam logic [CntW-1:0] RstLast = CntW'(RstHoldCycles - 1);
  localparam logic [CntW-1:0] IsoLast = CntW'(IsoTimeout - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumIslands - 1);

  pwr_state_e            state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  dir_q, dir_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       rr_q, rr_d;
  logic [NumIslands-1:0] iso_q, iso_d;
  logic [NumIslands-1:0] clk_en_q, clk_en_d;
  logic [NumIslands-1:0] irst_q, irst_d;
  logic [NumIslands-1:0] on_q, on_d;
  logic [NumIslands-1:0] err_q, err_d;

  logic [NumIslands-1:0] pending;
  logic                  grant_valid;
  logic [IdxW-1:0]       grant_idx;

  // Errored islands are parked until software clears the flag.
  assign pending = (en_req_i ^ on_q) & ~err_q;

  carfield_island_pwr_sequencer_rr #(
    .NumIslands (NumIslands),
    .IdxW       (IdxW)
  ) u_rr (
    .pending_i (pending),
    .rr_ptr_i  (rr_q),
    .valid_o   (grant_valid),
    .idx_o     (grant_idx)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q + 1'b1;
    rr_d     = rr_q;
    iso_d    = iso_q;
    clk_en_d = clk_en_q;
    irst_d   = irst_q;
    on_d     = on_q;
    // Clear first so a timeout in the same cycle overrides it.
    err_d    = err_q & ~err_clr_i;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (grant_valid) begin
          idx_d = grant_idx;
          dir_d = en_req_i[grant_idx];
          rr_d  = (grant_idx == IdxLast) ? '0 : grant_idx + 1'b1;
          if (en_req_i[grant_idx]) begin
            clk_en_d[grant_idx] = 1'b1;
            state_d             = StClkOn;
          end else begin
            iso_d[grant_idx] = 1'b1;
            state_d          = StIsoOn;
          end
        end
      end
      StClkOn: begin
        if (cnt_q == ClkLast) begin
          cnt_d         = '0;
          irst_d[idx_q] = 1'b0;
          state_d       = StRstOff;
        end
      end
      StRstOff: begin
        if (cnt_q == RstLast) begin
          cnt_d        = '0;
          iso_d[idx_q] = 1'b0;
          state_d      = StIsoOff;
        end
      end
      StIsoOff: begin
        if (!isolated_i[idx_q]) begin
          cnt_d   = '0;
          state_d = StDone;
        end else if (cnt_q == IsoLast) begin
          // Leave the island clocked and out of reset but isolated.
          cnt_d        = '0;
          err_d[idx_q] = 1'b1;
          iso_d[idx_q] = 1'b1;
          state_d      = StIdle;
        end
      end
      StIsoOn: begin
        if (isolated_i[idx_q] || (cnt_q == IsoLast)) begin
          // A missing ack still shuts the island down.
          if (!isolated_i[idx_q]) err_d[idx_q] = 1'b1;
          cnt_d           = '0;
          clk_en_d[idx_q] = 1'b0;
          state_d         = StClkOff;
        end
      end
      StClkOff: begin
        if (cnt_q == ClkLast) begin
          cnt_d         = '0;
          irst_d[idx_q] = 1'b1;
          state_d       = StRstOn;
        end
      end
      StRstOn: begin
        cnt_d   = '0;
        state_d = StDone;
      end
      StDone: begin
        cnt_d       = '0;
        on_d[idx_q] = dir_q;
        state_d     = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      rr_q     <= '0;
      iso_q    <= '1;
      clk_en_q <= '0;
      irst_q   <= '1;
      on_q     <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      iso_q    <= iso_d;
      clk_en_q <= clk_en_d;
      irst_q   <= irst_d;
      on_q     <= on_d;
      err_q    <= err_d;
    end
  end

  assign isolate_o    = iso_q;
  assign clk_en_o     = clk_en_q;
  assign island_rst_o = irst_q;
  assign island_on_o  = on_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_carfield_island_pwr_sequencer.sv
module tb_carfield_island_pwr_sequencer;

  localparam int unsigned N = 4;
  localparam int S = 8;
  localparam int H = 16;
  localparam int T = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] en_req, isolated, err_clr;
  logic [N-1:0] isolate_o, clk_en_o, island_rst_o, island_on_o, err_o;
  logic         busy_o;

  always #5 clk = ~clk;

  carfield_island_pwr_sequencer #(
    .NumIslands      (N),
    .ClkSettleCycles (S),
    .RstHoldCycles   (H),
    .IsoTimeout      (T)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_req_i     (en_req),
    .isolated_i   (isolated),
    .err_clr_i    (err_clr),
    .isolate_o    (isolate_o),
    .clk_en_o     (clk_en_o),
    .island_rst_o (island_rst_o),
    .island_on_o  (island_on_o),
    .err_o        (err_o),
    .busy_o       (busy_o)
  );

  // Isolation cells: ack follows the request two cycles later unless forced.
  logic [N-1:0] ack_d1, ack_d2, stuck_en, stuck_val;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_d1 <= '1;
      ack_d2 <= '1;
    end else begin
      ack_d1 <= isolate_o;
      ack_d2 <= ack_d1;
    end
  end
  assign isolated = (stuck_en & stuck_val) | (~stuck_en & ack_d2);

  // Reference model: one transaction at a time, step times derived from the grant time.
  typedef enum logic [2:0] {MIdle, MUpTimed, MUpAck, MDownAck, MDownTimed, MDone} mphase_e;
  mphase_e      ph;
  int           cyc, t_mark, cur, rr;
  logic         cur_dir;
  logic [N-1:0] m_iso, m_clk, m_rst, m_on, m_err;
  int           checks, failures;

  localparam logic [5*N:0] ResetVec = {{N{1'b1}}, {N{1'b0}}, {N{1'b1}}, {N{1'b0}}, {N{1'b0}}, 1'b0};

  function automatic logic [5*N:0] obs();
    return {isolate_o, clk_en_o, island_rst_o, island_on_o, err_o, busy_o};
  endfunction

  function automatic logic [5*N:0] expv();
    return {m_iso, m_clk, m_rst, m_on, m_err, ph != MIdle};
  endfunction

  task automatic model_reset();
    ph = MIdle; rr = 0; cur = 0; cur_dir = 1'b0; t_mark = 0;
    m_iso = '1; m_clk = '0; m_rst = '1; m_on = '0; m_err = '0;
  endtask

  task automatic model_step(input logic s_rst, input logic [N-1:0] s_en,
                            input logic [N-1:0] s_iso, input logic [N-1:0] s_clr);
    logic [N-1:0] pend, nerr;
    bit found;
    int j;
    if (s_rst) begin
      model_reset();
      return;
    end
    nerr = m_err & ~s_clr;
    case (ph)
      MIdle: begin
        pend = (s_en ^ m_on) & ~m_err;
        found = 0;
        for (int i = 0; i < int'(N); i++) begin
          j = (rr + i) % int'(N);
          if (!found && pend[j]) begin found = 1; cur = j; end
        end
        if (found) begin
          cur_dir = s_en[cur];
          rr = (cur + 1) % int'(N);
          t_mark = cyc;
          if (cur_dir) begin m_clk[cur] = 1'b1; ph = MUpTimed; end
          else begin m_iso[cur] = 1'b1; ph = MDownAck; end
        end
      end
      MUpTimed: begin
        if (cyc == t_mark + S) m_rst[cur] = 1'b0;
        else if (cyc == t_mark + S + H) begin m_iso[cur] = 1'b0; ph = MUpAck; t_mark = cyc; end
      end
      MUpAck: begin
        if (!s_iso[cur]) ph = MDone;
        else if (cyc - t_mark == T) begin nerr[cur] = 1'b1; m_iso[cur] = 1'b1; ph = MIdle; end
      end
      MDownAck: begin
        if (s_iso[cur] || (cyc - t_mark == T)) begin
          if (!s_iso[cur]) nerr[cur] = 1'b1;
          m_clk[cur] = 1'b0; ph = MDownTimed; t_mark = cyc;
        end
      end
      MDownTimed: begin
        if (cyc == t_mark + S) m_rst[cur] = 1'b1;
        else if (cyc == t_mark + S + 1) ph = MDone;
      end
      MDone: begin
        m_on[cur] = cur_dir; ph = MIdle;
      end
      default: ph = MIdle;
    endcase
    m_err = nerr;
  endtask

  // Called at a falling edge; returns at the next falling edge with the model advanced.
  task automatic tick();
    logic s_rst;
    logic [N-1:0] s_en, s_iso, s_clr;
    s_rst = rst; s_en = en_req; s_iso = isolated; s_clr = err_clr;
    @(posedge clk);
    cyc++;
    model_step(s_rst, s_en, s_iso, s_clr);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (obs() !== ResetVec) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", obs(), ResetVec);
    end
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      tick();
      if (obs() !== ResetVec) bad++;
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL reset_idle_constant got=%0d deviating cycles exp=0", bad);
    end
  endtask

  task automatic test_single_up();
    int c0, t_clk, t_rst, t_iso, t_on;
    t_clk = -1; t_rst = -1; t_iso = -1; t_on = -1;
    en_req = 4'b0001;
    c0 = cyc;
    repeat (40) begin
      tick();
      if (t_clk < 0 && clk_en_o[0]) t_clk = cyc - c0;
      if (t_rst < 0 && !island_rst_o[0]) t_rst = cyc - c0;
      if (t_iso < 0 && !isolate_o[0]) t_iso = cyc - c0;
      if (t_on < 0 && island_on_o[0]) t_on = cyc - c0;
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL single_up cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    checks++;
    if ({t_clk, t_rst, t_iso, t_on} !== {32'sd1, 32'sd9, 32'sd25, 32'sd29}) begin
      failures++;
      $display("FAIL single_up_timing got clk=%0d rst=%0d iso=%0d on=%0d exp 1 9 25 29",
               t_clk, t_rst, t_iso, t_on);
    end
  endtask

  task automatic test_back_to_back();
    int gaps, n;
    int order[$];
    logic [N-1:0] prev;
    rst = 1'b1; tick(); rst = 1'b0;
    // Power everything up at once.
    en_req = '1; gaps = 0; n = 0; prev = island_on_o;
    while (!(m_on == '1 && ph == MIdle) && n < 500) begin
      tick(); n++;
      for (int i = 0; i < int'(N); i++) if (island_on_o[i] && !prev[i]) order.push_back(i);
      prev = island_on_o;
      if (!busy_o && island_on_o != '1) gaps++;
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL all_up cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    checks++;
    if (n >= 500) begin failures++; $display("FAIL all_up_bound got=%0d cycles exp<500", n); end
    checks++;
    if (gaps != 3) begin failures++; $display("FAIL all_up_gaps got=%0d exp=3", gaps); end
    checks++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3)
    begin
      failures++; $display("FAIL all_up_order got=%p exp=0,1,2,3", order);
    end
    // And all down again.
    order.delete();
    en_req = '0; n = 0; prev = island_on_o;
    while (!(m_on == '0 && ph == MIdle) && n < 500) begin
      tick(); n++;
      for (int i = 0; i < int'(N); i++) if (!island_on_o[i] && prev[i]) order.push_back(i);
      prev = island_on_o;
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL all_down cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    checks++;
    if (n >= 500 || order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 ||
        order[3] != 3) begin
      failures++; $display("FAIL all_down_order got=%p after %0d cycles exp=0,1,2,3", order, n);
    end
  endtask

  task automatic test_down_timeout();
    int n, c0, t_err;
    en_req = 4'b0100; n = 0;
    while (!(m_on[2] && ph == MIdle) && n < 100) begin
      tick(); n++;
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL down_to_prep cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    stuck_en = 4'b0100; stuck_val = 4'b0000;
    en_req = '0; n = 0; c0 = cyc; t_err = -1;
    while (!(m_err[2] && ph == MIdle) && n < 1200) begin
      tick(); n++;
      if (t_err < 0 && err_o[2]) t_err = cyc - c0;
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL down_to cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    checks++;
    if (t_err != T + 1) begin failures++; $display("FAIL down_to_time got=%0d exp=%0d", t_err, T + 1); end
    checks++;
    if ({err_o[2], clk_en_o[2], island_rst_o[2], island_on_o[2]} !== 4'b1010) begin
      failures++;
      $display("FAIL down_to_state got err=%b clk=%b rst=%b on=%b exp 1 0 1 0",
               err_o[2], clk_en_o[2], island_rst_o[2], island_on_o[2]);
    end
    err_clr = 4'b0100; tick(); err_clr = '0; tick();
    checks++;
    if (err_o[2] !== 1'b0 || obs() !== expv()) begin
      failures++; $display("FAIL down_to_clear got err=%b exp 0", err_o[2]);
    end
    stuck_en = '0;
  endtask

  task automatic test_up_timeout();
    int n;
    bit pulsed;
    stuck_en = 4'b0010; stuck_val = 4'b0010;
    en_req = 4'b0010; n = 0;
    while (!(m_err[1] && ph == MIdle) && n < 1200) begin
      tick(); n++;
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL up_to cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    checks++;
    if ({err_o[1], isolate_o[1], island_on_o[1], clk_en_o[1], island_rst_o[1]} !== 5'b11010) begin
      failures++;
      $display("FAIL up_to_state got err=%b iso=%b on=%b clk=%b rst=%b exp 1 1 0 1 0",
               err_o[1], isolate_o[1], island_on_o[1], clk_en_o[1], island_rst_o[1]);
    end
    repeat (50) begin
      tick();
      checks++;
      if (busy_o !== 1'b0) begin failures++; $display("FAIL up_to_no_regrant got busy=%b exp 0", busy_o); end
    end
    // Clear, let the retry time out again and clear in that very cycle.
    err_clr = 4'b0010; tick();
    n = 0; pulsed = 0;
    while (!(pulsed && ph == MIdle) && n < 1200) begin
      if (ph == MUpAck && cyc + 1 - t_mark == T) begin err_clr = 4'b0010; pulsed = 1; end
      else err_clr = '0;
      tick(); n++;
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL up_to_retry cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    err_clr = '0;
    checks++;
    if (!pulsed || err_o[1] !== 1'b1) begin
      failures++; $display("FAIL set_wins got err=%b pulsed=%0d exp err=1", err_o[1], pulsed);
    end
    stuck_en = '0;
    err_clr = 4'b0010; tick(); err_clr = '0;
    n = 0;
    while (!(m_on[1] && ph == MIdle) && n < 100) begin
      tick(); n++;
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL up_recover cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    checks++;
    if (island_on_o[1] !== 1'b1) begin failures++; $display("FAIL up_recover_on got=%b exp 1", island_on_o[1]); end
  endtask

  task automatic test_random();
    repeat (2500) begin
      if ($urandom_range(0, 39) == 0) en_req = N'($urandom_range(0, 15));
      err_clr = ($urandom_range(0, 99) == 0) ? N'($urandom_range(0, 15)) : '0;
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    err_clr = '0;
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1; en_req = '0; tick(); rst = 1'b0;
    en_req = 4'b1000; n = 0;
    while (!(ph == MUpTimed && cyc >= t_mark + S + 3) && n < 50) begin
      tick(); n++;
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL reset_mid_prep cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
    checks++;
    if (island_rst_o[3] !== 1'b0 || clk_en_o[3] !== 1'b1) begin
      failures++; $display("FAIL reset_mid_phase got rst=%b clk=%b exp 0 1", island_rst_o[3], clk_en_o[3]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== ResetVec) begin
      failures++; $display("FAIL reset_mid_async got=%h exp=%h", obs(), ResetVec);
    end
    en_req = '0;
    tick();
    rst = 1'b0;
    repeat (20) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc, obs(), expv());
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; en_req = '0; err_clr = '0; stuck_en = '0; stuck_val = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_up();
    test_back_to_back();
    test_down_timeout();
    test_up_timeout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
